// File: rtl/driver_op_arb_pkg.sv
// Shared types and default widths for the driver_operation arbiter.
package driver_op_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEF_OP_W   = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Counter must reach TIMEOUT_CYCLES-1; a disabled timeout still needs one bit.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/driver_op_arbiter_if.sv
// Requester-side and driver-side handshake bundle of the driver_operation arbiter.
interface driver_op_arbiter_if
    import driver_op_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int OP_W    = DEF_OP_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OP_W-1:0]   req_operation;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_value;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_timeout;

    logic                      drv_start;
    logic [OP_W-1:0]           drv_operation;
    logic [ADDR_W-1:0]         drv_address;
    logic [DATA_W-1:0]         drv_value;
    logic                      drv_done;
    logic [DATA_W-1:0]         drv_return;

    // The arbiter sits on the slave side; requesters and the driver form the master side.
    modport slave (
        input  req_valid, req_operation, req_address, req_value, drv_done, drv_return,
        output req_ready, rsp_valid, rsp_data, rsp_timeout,
               drv_start, drv_operation, drv_address, drv_value
    );

    modport master (
        output req_valid, req_operation, req_address, req_value, drv_done, drv_return,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout,
               drv_start, drv_operation, drv_address, drv_value
    );

endinterface

// File: rtl/driver_op_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: search upward from last_grant+1 with wrap.
module rr_arbiter
    import driver_op_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        found     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found                 = 1'b1;
                grant[IDX_W'(cand)]   = 1'b1;
                grant_idx             = IDX_W'(cand);
                grant_vld             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/driver_op_arbiter.sv
// Shares a single driver_operation port among NUM_REQ requesters with round-robin
// arbitration, a per-transaction timeout and a one-cycle response strobe.
module driver_op_arbiter
    import driver_op_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int OP_W           = DEF_OP_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clock,
    input  logic                reset,
    driver_op_arbiter_if.slave  bus,
    output logic                busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic [NUM_REQ-1:0]  req_ready_c;
    logic [NUM_REQ-1:0]  rsp_valid_c;
    logic                drv_start_c;

    logic [OP_W-1:0]     op_slice   [NUM_REQ];
    logic [ADDR_W-1:0]   addr_slice [NUM_REQ];
    logic [DATA_W-1:0]   val_slice  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_slice[g]   = bus.req_operation[g*OP_W +: OP_W];
        assign addr_slice[g] = bus.req_address[g*ADDR_W +: ADDR_W];
        assign val_slice[g]  = bus.req_value[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            val_q         <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            val_q         <= val_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // drv_done is only looked at in WAIT, and it takes priority over an expiring timeout.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        addr_d        = addr_q;
        val_d         = val_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        req_ready_c   = '0;
        rsp_valid_c   = '0;
        drv_start_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_c = grant;
                if (grant_vld) begin
                    owner_d = grant_idx;
                    op_d    = op_slice[grant_idx];
                    addr_d  = addr_slice[grant_idx];
                    val_d   = val_slice[grant_idx];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                drv_start_c = 1'b1;
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.drv_done) begin
                    rsp_data_d    = bus.drv_return;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                rsp_valid_c[owner_q] = 1'b1;
                last_grant_d         = owner_q;
                state_d              = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.drv_start     = drv_start_c;
    assign bus.drv_operation = op_q;
    assign bus.drv_address   = addr_q;
    assign bus.drv_value     = val_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_driver_op_arbiter.sv
// Directed bench for driver_op_arbiter with TIMEOUT_CYCLES=16; inputs change 1ns after
// each rising edge and outputs are compared 2ns after it.
module tb_driver_op_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   vec_count  = 0;
    int   miss_count = 0;

    driver_op_arbiter_if #(.NUM_REQ(3), .OP_W(2), .ADDR_W(32), .DATA_W(32)) bus ();

    driver_op_arbiter #(
        .NUM_REQ(3), .OP_W(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic done, input logic [31:0] ret);
        bus.req_valid  = valid;
        bus.drv_done   = done;
        bus.drv_return = ret;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miss_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle where valid is already applied; returns in the RESP cycle.
    task automatic run_txn(input string tag, input logic [2:0] valid, input logic [2:0] exp_grant,
                           input logic hold, input logic start_done, input int done_wait,
                           input logic [31:0] ret, input logic [1:0] e_op, input logic [31:0] e_addr,
                           input logic [31:0] e_val, input logic e_to, input logic [31:0] e_data);
        int n_wait;
        n_wait = (done_wait >= 1 && done_wait <= 16) ? done_wait : 16;
        checkOutput({tag, ".idle_ready"}, 32'(bus.req_ready), 32'(exp_grant));
        checkOutput({tag, ".idle_busy"}, 32'(busy), 32'd0);

        tick();
        applyStimulus(hold ? valid : 3'b000, start_done, start_done ? 32'hEE : 32'h0);
        checkOutput({tag, ".start_pulse"}, 32'(bus.drv_start), 32'd1);
        checkOutput({tag, ".start_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, ".start_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".drv_op"}, 32'(bus.drv_operation), 32'(e_op));
        checkOutput({tag, ".drv_addr"}, bus.drv_address, e_addr);
        checkOutput({tag, ".drv_val"}, bus.drv_value, e_val);

        for (int w = 1; w <= n_wait; w++) begin
            tick();
            applyStimulus(hold ? valid : 3'b000, (w == done_wait), ret);
            checkOutput({tag, ".wait_start"}, 32'(bus.drv_start), 32'd0);
            checkOutput({tag, ".wait_ready"}, 32'(bus.req_ready), 32'd0);
            checkOutput({tag, ".wait_rsp"}, 32'(bus.rsp_valid), 32'd0);
        end

        tick();
        applyStimulus(hold ? valid : 3'b000, 1'b0, 32'h0);
        checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_grant));
        checkOutput({tag, ".rsp_data"}, bus.rsp_data, e_data);
        checkOutput({tag, ".rsp_timeout"}, 32'(bus.rsp_timeout), 32'(e_to));
        checkOutput({tag, ".rsp_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, ".rsp_addr_hold"}, bus.drv_address, e_addr);
    endtask

    initial begin
        bus.req_valid     = '0;
        bus.drv_done      = 1'b0;
        bus.drv_return    = '0;
        bus.req_operation = {2'd3, 2'd2, 2'd1};
        bus.req_address   = {32'h108, 32'h104, 32'h100};
        bus.req_value     = {32'hA2, 32'hA1, 32'hA0};

        #2 reset = 1'b0;
        #1;
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst.rsp_data", bus.rsp_data, 32'd0);
        checkOutput("rst.drv_start", 32'(bus.drv_start), 32'd0);
        checkOutput("rst.drv_addr", bus.drv_address, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        tick(); applyStimulus(3'b111, 1'b0, 32'h0);
        run_txn("rot0", 3'b111, 3'b001, 1'b1, 1'b0, 1, 32'h11, 2'd1, 32'h100, 32'hA0, 1'b0, 32'h11);
        tick(); applyStimulus(3'b111, 1'b0, 32'h0);
        run_txn("rot1", 3'b111, 3'b010, 1'b1, 1'b0, 1, 32'h22, 2'd2, 32'h104, 32'hA1, 1'b0, 32'h22);
        tick(); applyStimulus(3'b111, 1'b0, 32'h0);
        run_txn("rot2", 3'b111, 3'b100, 1'b1, 1'b0, 1, 32'h33, 2'd3, 32'h108, 32'hA2, 1'b0, 32'h33);
        tick(); applyStimulus(3'b111, 1'b0, 32'h0);
        run_txn("rot3", 3'b111, 3'b001, 1'b1, 1'b0, 1, 32'h44, 2'd1, 32'h100, 32'hA0, 1'b0, 32'h44);

        bus.req_address = {32'h108, 32'h104, 32'h10};
        bus.req_value   = {32'hA2, 32'hA1, 32'hAB};
        tick(); applyStimulus(3'b001, 1'b0, 32'h0);
        run_txn("single", 3'b001, 3'b001, 1'b0, 1'b0, 3, 32'h55, 2'd1, 32'h10, 32'hAB, 1'b0, 32'h55);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        checkOutput("single.idle_busy", 32'(busy), 32'd0);
        checkOutput("single.data_hold", bus.rsp_data, 32'h55);

        tick(); applyStimulus(3'b010, 1'b0, 32'h0);
        run_txn("tmo", 3'b010, 3'b010, 1'b0, 1'b0, 0, 32'h99, 2'd2, 32'h104, 32'hA1, 1'b1, 32'h0);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        checkOutput("tmo.flag_hold", 32'(bus.rsp_timeout), 32'd1);

        tick(); applyStimulus(3'b100, 1'b0, 32'h0);
        run_txn("after_tmo", 3'b100, 3'b100, 1'b0, 1'b0, 2, 32'h42, 2'd3, 32'h108, 32'hA2, 1'b0, 32'h42);

        tick(); applyStimulus(3'b101, 1'b0, 32'h0);
        run_txn("done16", 3'b101, 3'b001, 1'b0, 1'b0, 16, 32'h77, 2'd1, 32'h10, 32'hAB, 1'b0, 32'h77);

        tick(); applyStimulus(3'b011, 1'b0, 32'h0);
        run_txn("start_done", 3'b011, 3'b010, 1'b0, 1'b1, 2, 32'h33, 2'd2, 32'h104, 32'hA1, 1'b0, 32'h33);

        tick(); applyStimulus(3'b001, 1'b0, 32'h0);
        checkOutput("rst_mid.ready", 32'(bus.req_ready), 32'b001);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        checkOutput("rst_mid.start", 32'(bus.drv_start), 32'd1);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        checkOutput("rst_mid.wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid.busy", 32'(busy), 32'd0);
        checkOutput("rst_mid.drv_op", 32'(bus.drv_operation), 32'd0);
        checkOutput("rst_mid.drv_addr", bus.drv_address, 32'd0);
        checkOutput("rst_mid.drv_val", bus.drv_value, 32'd0);
        checkOutput("rst_mid.rsp_data", bus.rsp_data, 32'd0);
        checkOutput("rst_mid.rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        checkOutput("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        applyStimulus(3'b000, 1'b1, 32'hDD);
        checkOutput("rst_mid.late_done_rsp", 32'(bus.rsp_valid), 32'd0);
        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        checkOutput("rst_mid.late_done_rsp2", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_mid.late_done_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid.late_done_data", bus.rsp_data, 32'd0);

        tick(); applyStimulus(3'b111, 1'b0, 32'h0);
        run_txn("post_rst", 3'b111, 3'b001, 1'b1, 1'b0, 1, 32'h5A, 2'd1, 32'h10, 32'hAB, 1'b0, 32'h5A);

        tick(); applyStimulus(3'b000, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/driver_op_arbiter.md
DRIVER_OP_ARBITER -- requirements
Module: driver_op_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing driver_operation (2..8).
REQ-002 Parameter OP_W, default 2: operation code width.
REQ-003 Parameter ADDR_W, default 32: address width.
REQ-004 Parameter DATA_W, default 32: value/return width.
REQ-005 Parameter TIMEOUT_CYCLES, default 65535: maximum WAIT cycles; 0 disables the timeout.
REQ-006 clock  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester request; held high until accepted.
REQ-009 req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
REQ-010 req_operation / req_address / req_value  in  NUM_REQ*OP_W / NUM_REQ*ADDR_W / NUM_REQ*DATA_W  packed request fields, requester i in slice i.
REQ-011 rsp_valid  out  NUM_REQ  one-cycle response strobe to the owning requester.
REQ-012 rsp_data  out  DATA_W  response data, valid while any rsp_valid bit is high.
REQ-013 rsp_timeout  out  1  response is a timeout, valid with rsp_valid.
REQ-014 drv_start  out  1  to driver_operation start_port.
REQ-015 drv_operation / drv_address / drv_value  out  OP_W / ADDR_W / DATA_W  to driver_operation operation/address/value.
REQ-016 drv_done  in  1  from done_port.
REQ-017 drv_return  in  DATA_W  from return_port.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 The FSM SHALL use the states IDLE, START, WAIT and RESP; transitions are IDLE->START, START->WAIT, WAIT->RESP and RESP->IDLE.
REQ-020 In IDLE, req_ready SHALL be set combinationally for the round-robin winner among the req_valid bits, searching from last_grant+1 upward with wrap.
- The request transfers on the edge where valid&ready; the winner's fields are latched, owner:=winner, next state START.
REQ-021 req_ready SHALL be all-zero outside IDLE or when no req_valid bit is high.
REQ-022 In START, drv_start SHALL be high for exactly one cycle; next state WAIT; the timeout counter clears to 0.
REQ-023 drv_operation, drv_address and drv_value SHALL be driven from the latched registers and held stable from START through RESP.
REQ-024 drv_done SHALL be sampled only in WAIT; a drv_done in IDLE, START or RESP is ignored.
REQ-025 In WAIT with drv_done=1, the block SHALL set rsp_data:=drv_return and rsp_timeout:=0, then move to RESP.
REQ-026 In WAIT without drv_done, the counter SHALL increment each cycle.
- When the counter equals TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0: rsp_data:=0, rsp_timeout:=1, move to RESP.
- WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
REQ-027 When drv_done and the timeout condition occur in the same cycle, done SHALL win.
REQ-028 In RESP, rsp_valid[owner] SHALL be high for exactly one cycle and last_grant:=owner; next state IDLE.
- rsp_data and rsp_timeout hold their values until the next RESP.
REQ-029 Latency SHALL be as follows.
- Accept at edge N gives drv_start in cycle N+1.
- The earliest done is in cycle N+2.
- rsp_valid is in the cycle after done.
- A new accept can occur in the cycle after RESP, so the minimum period is 4 cycles.
REQ-030 Continuously asserted requesters SHALL be served in strict rotation 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.

Reset
REQ-031 When reset is low, the block SHALL asynchronously apply the following.
- State IDLE; last_grant:=NUM_REQ-1, so requester 0 wins first.
- Counter 0; owner 0.
- drv_start, drv_operation, drv_address, drv_value, rsp_valid, rsp_data, rsp_timeout and busy all 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it with no rsp_valid.
- A drv_done arriving after release is ignored unless the state is WAIT.

Structure
REQ-033 Package driver_op_arb_pkg SHALL hold the FSM state enum and the default OP_W, ADDR_W and DATA_W constants.
REQ-034 A combinational sub-module rr_arbiter (request vector, last_grant -> one-hot grant and index) SHALL implement the winner selection.
REQ-035 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.

Verification
REQ-036 Single request: req0 with op=1, addr=0x10, value=0xAB; drv_done with return 0x55 three cycles after start.
- Expect one drv_start pulse carrying 1/0x10/0xAB.
- Expect rsp_valid=3'b001 for one cycle with rsp_data=0x55 and rsp_timeout=0.
REQ-037 All three req_valid held high.
- Expect grant order 0,1,2,0.
- Expect req_ready one-hot and never high outside IDLE.
REQ-038 TIMEOUT_CYCLES=16, drv_done never asserted.
- Expect rsp_valid at the cycle after the 16th WAIT cycle, with rsp_timeout=1 and rsp_data=0.
- Expect the next request to proceed normally.
REQ-039 TIMEOUT_CYCLES=16, drv_done with return 0x77 in the 16th WAIT cycle: expect rsp_timeout=0 and rsp_data=0x77.
REQ-040 Reset pulled low in WAIT, then drv_done pulsed after release.
- Expect all outputs 0 immediately and no rsp_valid.
- Expect the next grant to go to req0.
REQ-041 drv_done asserted during the START cycle.
- Expect it to be ignored: the FSM stays in WAIT until a later done.
